// File: rtl/mux_pkt_arb_if.sv
// mux_pkt_arb_if: handshake bundle between the 2:1 flit mux senders/sink
// and the packet arbiter.
//   master : flit sources and downstream sink side (drives valid/type/oready)
//   slave  : arbiter side (drives per-input ready, mux select and status)
// Signals:
//   ivalid_0/1, itype_0/1 : per-input flit valid and type (NONE/HEAD/TAIL/DATA)
//   oready                : downstream can take a flit this cycle
//   iready_0/1            : per-input flit accepted this cycle
//   sel                   : one-hot mux select (SELW bits)
//   busy, pkt_cnt, err    : lock status, flits in current packet, error pulse
interface mux_pkt_arb_if #(
  parameter int SELW = 5,
  parameter int CNTW = 8
);
  logic            ivalid_0;
  logic [1:0]      itype_0;
  logic            ivalid_1;
  logic [1:0]      itype_1;
  logic            oready;
  logic            iready_0;
  logic            iready_1;
  logic [SELW-1:0] sel;
  logic            busy;
  logic [CNTW-1:0] pkt_cnt;
  logic            err;

  modport master (
    output ivalid_0, itype_0, ivalid_1, itype_1, oready,
    input  iready_0, iready_1, sel, busy, pkt_cnt, err
  );

  modport slave (
    input  ivalid_0, itype_0, ivalid_1, itype_1, oready,
    output iready_0, iready_1, sel, busy, pkt_cnt, err
  );
endinterface

// File: rtl/mux_pkt_arb.sv
// mux_pkt_arb: packet-level round-robin arbiter for a 2:1 flit mux.
// Grants an input on a HEAD flit, holds the mux select until that input's
// TAIL (or the MAXLEN watchdog), then hands priority to the other input.
// Ports:
//   clk  : clock, rising edge
//   rst_ : asynchronous reset, active low
//   bus  : mux_pkt_arb_if.slave (flit valid/type in, ready/sel/status out)
module mux_pkt_arb #(
  parameter int SELW   = 5,
  parameter int CNTW   = 8,
  parameter int MAXLEN = 32
) (
  input  logic         clk,
  input  logic         rst_,
  mux_pkt_arb_if.slave bus
);
  localparam logic [1:0]    T_HEAD  = 2'b01;
  localparam logic [1:0]    T_TAIL  = 2'b10;
  localparam logic [CNTW:0] MAX_CNT = (CNTW+1)'(MAXLEN);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            prio_q, prio_d;
  logic            err_q, err_d;

  logic [1:0]      vld, elig;
  logic [1:0][1:0] typ;
  logic [1:0]      cur_typ;
  logic            own, gnt, xfer, at_max;

  assign vld     = {bus.ivalid_1, bus.ivalid_0};
  assign typ     = {bus.itype_1, bus.itype_0};
  assign elig    = {vld[1] && (typ[1] == T_HEAD), vld[0] && (typ[0] == T_HEAD)};
  // index of the locked input; only meaningful outside IDLE
  assign own     = (state_q == LOCK1);
  assign cur_typ = typ[own];
  assign xfer    = (state_q != IDLE) && vld[own] && bus.oready;
  // this transfer would be flit number MAXLEN of the packet
  assign at_max  = ({1'b0, cnt_q} + (CNTW+1)'(1)) == MAX_CNT;
  assign gnt     = (&elig) ? prio_q : elig[1];

  assign bus.iready_0 = (state_q == LOCK0) && bus.oready;
  assign bus.iready_1 = (state_q == LOCK1) && bus.oready;
  assign bus.sel      = sel_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.pkt_cnt  = cnt_q;
  assign bus.err      = err_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // head is only observed here; it is consumed once locked
        if (|elig) begin
          state_d = gnt ? LOCK1 : LOCK0;
          sel_d   = gnt ? SELW'(2) : SELW'(1);
          cnt_d   = '0;
        end
      end
      default: begin
        if (xfer) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
          if ((cur_typ == T_HEAD) && (cnt_q != '0)) err_d = 1'b1;
          // TAIL beats the watchdog when both land on the same flit
          if ((cur_typ == T_TAIL) || at_max) begin
            state_d = IDLE;
            sel_d   = '0;
            prio_d  = ~own;
          end
          if ((cur_typ != T_TAIL) && at_max) err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mux_pkt_arb.sv
// tb_mux_pkt_arb: directed scenarios plus randomized traffic against a
// packet-level reference model (owner index, flit count, priority).
module tb_mux_pkt_arb;
  localparam int SELW   = 5;
  localparam int CNTW   = 8;
  localparam int MAXLEN = 32;
  localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_DATA = 2'b11;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  mux_pkt_arb_if #(.SELW(SELW), .CNTW(CNTW)) bus();

  mux_pkt_arb #(.SELW(SELW), .CNTW(CNTW), .MAXLEN(MAXLEN)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // pending flits per sender
  logic [1:0] q[2][$];

  // reference model: -1 = no packet owner
  int m_own  = -1;
  int m_cnt  = 0;
  int m_prio = 0;
  bit m_err  = 1'b0;

  int vprob    = 100;
  int oprob    = 100;
  int or_force = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
  endtask

  task automatic push_pkt(input int i, input int mids, input bit tail, input bit noisy);
    q[i].push_back(T_HEAD);
    for (int k = 0; k < mids; k++) begin
      if (noisy && $urandom_range(15) == 0)      q[i].push_back(T_HEAD);
      else if (noisy && $urandom_range(7) == 0)  q[i].push_back(T_NONE);
      else                                       q[i].push_back(T_DATA);
    end
    if (tail) q[i].push_back(T_TAIL);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("rst_sel",  32'(bus.sel),      32'd0);
    chk("rst_busy", 32'(bus.busy),     32'd0);
    chk("rst_cnt",  32'(bus.pkt_cnt),  32'd0);
    chk("rst_err",  32'(bus.err),      32'd0);
    chk("rst_ir0",  32'(bus.iready_0), 32'd0);
    chk("rst_ir1",  32'(bus.iready_1), 32'd0);
    m_own = -1; m_cnt = 0; m_prio = 0; m_err = 1'b0;
    q[0].delete();
    q[1].delete();
    bus.ivalid_0 = 1'b0;
    bus.ivalid_1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
  endtask

  // one clock: drive at negedge, check at negedge+1, advance model for the
  // following rising edge
  task automatic cycle();
    bit         v[2];
    logic [1:0] t[2];
    bit         o;
    bit         h0, h1;
    int         k;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      v[i] = (q[i].size() > 0) && ($urandom_range(99) < vprob);
      t[i] = v[i] ? q[i][0] : 2'($urandom_range(3));
    end
    o = (or_force < 0) ? ($urandom_range(99) < oprob) : or_force[0];
    bus.ivalid_0 = v[0]; bus.itype_0 = t[0];
    bus.ivalid_1 = v[1]; bus.itype_1 = t[1];
    bus.oready   = o;
    #1;
    chk("sel",      32'(bus.sel),      (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("busy",     32'(bus.busy),     32'(m_own >= 0));
    chk("pkt_cnt",  32'(bus.pkt_cnt),  32'(m_cnt));
    chk("err",      32'(bus.err),      32'(m_err));
    chk("iready_0", 32'(bus.iready_0), 32'(m_own == 0 && o));
    chk("iready_1", 32'(bus.iready_1), 32'(m_own == 1 && o));

    m_err = 1'b0;
    if (m_own < 0) begin
      h0 = v[0] && (t[0] == T_HEAD);
      h1 = v[1] && (t[1] == T_HEAD);
      if (h0 && h1)  m_own = m_prio;
      else if (h0)   m_own = 0;
      else if (h1)   m_own = 1;
      if (h0 || h1)  m_cnt = 0;
      // senders abandon stray non-head flits that nobody will accept
      for (int i = 0; i < 2; i++)
        if (v[i] && t[i] != T_HEAD) void'(q[i].pop_front());
    end else begin
      k = m_own;
      if (v[k] && o) begin
        void'(q[k].pop_front());
        if (t[k] == T_HEAD && m_cnt != 0) m_err = 1'b1;
        if (m_cnt < (1 << CNTW) - 1) m_cnt++;
        if (t[k] == T_TAIL) begin
          m_prio = 1 - k; m_own = -1;
        end else if (m_cnt == MAXLEN) begin
          m_err = 1'b1; m_prio = 1 - k; m_own = -1;
        end
      end
      if (v[1-k] && t[1-k] != T_HEAD) void'(q[1-k].pop_front());
    end
  endtask

  initial begin
    bus.ivalid_0 = 1'b0; bus.itype_0 = T_NONE;
    bus.ivalid_1 = 1'b0; bus.itype_1 = T_NONE;
    bus.oready   = 1'b0;
    do_reset();

    // single long packet on input 1
    push_pkt(1, 20, 1'b1, 1'b0);
    repeat (28) cycle();

    // simultaneous heads straight after reset: input 0 first
    do_reset();
    push_pkt(0, 3, 1'b1, 1'b0);
    push_pkt(1, 3, 1'b1, 1'b0);
    repeat (16) cycle();

    // back-pressure: 10-flit packet, oready low for 3 cycles after flit 4
    push_pkt(0, 8, 1'b1, 1'b0);
    or_force = 1; repeat (5) cycle();
    or_force = 0; repeat (3) cycle();
    or_force = 1; repeat (8) cycle();
    or_force = -1;

    // watchdog: no tail
    push_pkt(1, MAXLEN + 3, 1'b0, 1'b0);
    repeat (MAXLEN + 10) cycle();

    // tail on exactly the MAXLEN-th flit
    push_pkt(0, MAXLEN - 2, 1'b1, 1'b0);
    repeat (MAXLEN + 4) cycle();

    // reset mid-packet after 5 flits, then simultaneous heads
    push_pkt(0, 8, 1'b1, 1'b0);
    repeat (6) cycle();
    do_reset();
    push_pkt(0, 2, 1'b1, 1'b0);
    push_pkt(1, 2, 1'b1, 1'b0);
    repeat (14) cycle();

    // stray DATA on input 0 alongside a HEAD on input 1
    q[0].push_back(T_DATA);
    push_pkt(1, 2, 1'b1, 1'b0);
    repeat (8) cycle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) begin
        vprob = 50 + $urandom_range(50);
        oprob = 40 + $urandom_range(60);
      end
      for (int i = 0; i < 2; i++) begin
        if (q[i].size() == 0 && $urandom_range(99) < 30) begin
          case ($urandom_range(9))
            0:       q[i].push_back(T_DATA);
            1:       push_pkt(i, MAXLEN + $urandom_range(3), 1'b0, 1'b1);
            2:       push_pkt(i, MAXLEN - 2, 1'b1, 1'b0);
            default: push_pkt(i, $urandom_range(8), 1'b1, 1'b1);
          endcase
        end
      end
      if ($urandom_range(999) == 0) do_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_pkt_arb.md
Name: mux_pkt_arb

Overview:
- Packet-level round-robin arbiter and sequencer for the 2:1 flit mux in the router output stage.
- Watches flit valid and type on both mux inputs and locks the mux select from head flit to tail flit.
- Returns per-input ready to the upstream senders, honours downstream back-pressure, and bounds packet length with a watchdog.
- Sits beside the mux; its sel output drives the mux sel port directly.

Parameters:
- SELW, 5: sel width; sel is one-hot, bit i selects input i; all-zero means no input selected.
- CNTW, 8: width of the flit counter.
- MAXLEN, 32: maximum number of flits per packet, head and tail included; must be at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_  in  1  asynchronous reset, active-low.
- ivalid_0  in  1  input 0 flit valid.
- itype_0  in  2  input 0 flit type, taken from the mux data MSBs: NONE=00, HEAD=01, TAIL=10, DATA=11.
- ivalid_1  in  1  input 1 flit valid.
- itype_1  in  2  input 1 flit type, same encoding as itype_0.
- oready  in  1  downstream can accept a flit this cycle.
- iready_0  out  1  input 0 flit is accepted this cycle.
- iready_1  out  1  input 1 flit is accepted this cycle.
- sel  out  SELW  one-hot mux select, registered.
- busy  out  1  a packet is locked (state is not IDLE).
- pkt_cnt  out  CNTW  flits transferred in the current packet.
- err  out  1  one-cycle pulse on a protocol violation or watchdog release.

Behaviour:
- Reset while rst_ is low, taking effect immediately:
  - state=IDLE, sel=0, busy=0, pkt_cnt=0, err=0, prio=0 (input 0 preferred), iready_0=iready_1=0.
  - Reset asserted mid-packet aborts the packet; nothing is retained.
- States: IDLE, LOCK0, LOCK1.
- IDLE:
  - Input i is eligible when ivalid_i=1 and itype_i=HEAD.
  - If both inputs are eligible, grant input prio. If only one is eligible, grant it.
  - On the next edge: state=LOCKi, sel=one-hot(i), pkt_cnt=0. Arbitration latency is 1 cycle.
  - iready_0 and iready_1 stay 0 in IDLE; the head flit is not consumed there.
  - Valid non-HEAD flits in IDLE are ignored: not granted, no err, they simply stall.
- LOCKi:
  - iready_i = oready, combinational from oready; iready of the other input = 0.
  - A transfer occurs when ivalid_i=1 and oready=1. Each transfer increments pkt_cnt.
  - A HEAD transfer with pkt_cnt not equal to 0: err pulse next cycle; flit passes; state unchanged.
  - A TAIL transfer: next state IDLE, sel=0, prio=1-i (the loser of the last round gets priority). pkt_cnt holds its final value until the next grant.
  - Watchdog: the transfer that brings pkt_cnt to MAXLEN without a TAIL triggers err pulse, state=IDLE, sel=0, prio=1-i.
  - A TAIL arriving on exactly the MAXLEN-th flit is legal: no err.
  - ivalid_i=0 or oready=0: no transfer; sel, pkt_cnt and state all hold.
  - A NONE-type valid flit counts as a transfer and passes through.
- Back-to-back packets:
  - Tail transfers at cycle t; IDLE at t+1; new LOCK at t+2.
  - There is a minimum one-cycle bubble between packets.
- Simultaneous events:
  - A new head on the other input during LOCK waits; it does not pre-empt.
  - Watchdog and TAIL on the same transfer: TAIL wins, no err.
- pkt_cnt saturates at 2^CNTW-1 and never wraps.

Test Plan:
- Input 1 only: HEAD, 20 DATA, TAIL, oready=1.
  - sel=5'b00010 one cycle after HEAD is presented; iready_1 high 22 cycles; pkt_cnt reaches 22.
  - Then sel=0, busy=0; err stays 0.
- Both inputs present HEAD in the same cycle after reset.
  - Input 0 locks first; iready_1=0 throughout.
  - After input 0's TAIL, the first IDLE cycle grants input 1; sel=5'b00010 two cycles after the tail.
- Back-pressure: input 0 packet of 10 flits; drop oready for 3 cycles after flit 4.
  - iready_0=0 for those cycles; pkt_cnt holds at 4; sel stays 5'b00001.
  - Packet completes with pkt_cnt=10.
- Watchdog with MAXLEN=8: input 1 sends HEAD plus 12 DATA with no TAIL.
  - err pulses once after the 8th transfer; state=IDLE; sel=0; prio=0.
- Assert rst_ low mid-packet, after 5 flits on input 0.
  - Without waiting for an edge: sel=0, iready_0=0, busy=0, pkt_cnt=0.
  - After release, simultaneous HEADs grant input 0 first.
- In IDLE, input 0 presents a DATA flit and input 1 presents a HEAD.
  - Input 1 is granted; input 0 receives no iready; err=0.
